// File: rtl/tone_seq_pkg.sv
// rtl/tone_seq_pkg.sv - shared state encoding and default sizing for the tone sequencer
package tone_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [3:0]  DEF_LAST_ADDR  = 4'd9;
    localparam logic [15:0] DEF_NOTE_TICKS = 16'd1000;

endpackage

// File: rtl/tone_seq_div.sv
// rtl/tone_seq_div.sv - half-period counter and square-wave toggle (module tone_div)
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high clear of div, half_cnt and tone
//   load - capture div, preload half_cnt = div-1, force tone low
//   div  - half-period length in cycles; 0 is a rest (tone held low)
//   en   - advance the half-period counter this cycle
//   tone - square-wave output, period 2*div cycles
module tone_div (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] div,
    input  logic       en,
    output logic       tone
);

    logic [7:0] div_q,  div_d;
    logic [7:0] half_q, half_d;
    logic       tone_q, tone_d;

    always_comb begin
        div_d  = div_q;
        half_d = half_q;
        tone_d = tone_q;
        if (rst) begin
            div_d  = 8'd0;
            half_d = 8'd0;
            tone_d = 1'b0;
        end else if (load) begin
            div_d  = div;
            half_d = div - 8'd1;
            tone_d = 1'b0;
        end else if (en) begin
            if (div_q == 8'd0) begin
                tone_d = 1'b0;
            end else if (half_q == 8'd0) begin
                tone_d = ~tone_q;
                half_d = div_q - 8'd1;
            end else begin
                half_d = half_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        div_q  <= div_d;
        half_q <= half_d;
        tone_q <= tone_d;
    end

    assign tone = tone_q;

endmodule

// File: rtl/tone_seq.sv
// rtl/tone_seq.sv - note-table sequencer: plays LAST_ADDR+1 notes of NOTE_TICKS cycles each
//
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset, highest priority
//   start    - single-cycle playback request, honoured only in IDLE
//   stop     - abort to IDLE, wins over start
//   db_entry - half-period divider read from the note table at addr (0 = rest)
//   addr     - registered note-table address
//   tone     - square-wave audio output
//   busy     - high in LOAD and PLAY
//   done     - one-cycle pulse when the final note ends
//
// Build option: define TONE_SEQ_LOOP_EN to wrap from the last note back to
// address 0 instead of finishing; playback then runs until stop or rst.
module tone_seq
    import tone_seq_pkg::*;
#(
    parameter logic [15:0] NOTE_TICKS = DEF_NOTE_TICKS,
    parameter logic [3:0]  LAST_ADDR  = DEF_LAST_ADDR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] db_entry,
    output logic [3:0] addr,
    output logic       tone,
    output logic       busy,
    output logic       done
);

    state_e      state_q, state_d;
    logic [3:0]  addr_q,  addr_d;
    logic [15:0] dur_q,   dur_d;
    logic        div_load;
    logic        div_en;
    logic        div_rst;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        dur_d    = dur_q;
        div_load = 1'b0;
        div_en   = 1'b0;
        if (rst || stop) begin
            state_d = IDLE;
            addr_d  = 4'd0;
            dur_d   = 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    addr_d = 4'd0;
                    if (start) begin
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    div_load = 1'b1;
                    dur_d    = NOTE_TICKS - 16'd1;
                    state_d  = PLAY;
                end
                PLAY: begin
                    div_en = 1'b1;
                    if (dur_q == 16'd0) begin
                        if (addr_q == LAST_ADDR) begin
                            addr_d = 4'd0;
`ifdef TONE_SEQ_LOOP_EN
                            state_d = LOAD;
`else
                            state_d = DONE;
`endif
                        end else begin
                            addr_d  = addr_q + 4'd1;
                            state_d = LOAD;
                        end
                    end else begin
                        dur_d = dur_q - 16'd1;
                    end
                end
                DONE: begin
                    addr_d  = 4'd0;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    addr_d  = 4'd0;
                end
            endcase
        end
    end

    // Clearing the divider whenever we land in IDLE or DONE keeps tone low
    // there and covers stop/rst without extra paths into the sub-block.
    assign div_rst = rst || (state_d == IDLE) || (state_d == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 4'd0;
            dur_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            dur_q   <= dur_d;
        end
    end

    tone_div u_div (
        .clk  (clk),
        .rst  (div_rst),
        .load (div_load),
        .div  (db_entry),
        .en   (div_en),
        .tone (tone)
    );

    assign addr = addr_q;
    assign busy = (state_q == LOAD) || (state_q == PLAY);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_tone_seq.sv
// tb/tb_tone_seq.sv - scoreboard bench for tone_seq (NOTE_TICKS=8, LAST_ADDR=9)
module tb_tone_seq;
    import tone_seq_pkg::*;

    localparam logic [15:0] NT = 16'd8;
    localparam logic [3:0]  LA = 4'd9;

    logic       clk = 1'b0;
    logic       rst, start, stop, corrupt;
    logic [7:0] db_entry;
    logic [3:0] addr;
    logic       tone, busy, done;
    logic [7:0] note_tab [0:9];

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0] addr;
        logic       tone;
        logic       busy;
        logic       done;
    } obs_t;

    obs_t exp_q[$];

    always #5 clk = ~clk;

    always_comb db_entry = corrupt ? 8'hA5 : ((addr <= 4'd9) ? note_tab[addr] : 8'd0);

    tone_seq #(.NOTE_TICKS(NT), .LAST_ADDR(LA)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .db_entry (db_entry),
        .addr     (addr),
        .tone     (tone),
        .busy     (busy),
        .done     (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_tone(int p, logic [7:0] d);
        int di;
        di = int'(d);
        if (di == 0) return 1'b0;
        return ((p / di) % 2) == 1;
    endfunction

    // Expected outputs n edges after the edge that accepted start; a note is
    // 9 cycles (LOAD + 8 PLAY).
    function automatic obs_t exp_at(int n);
        obs_t o;
        int k, r;
        k = n / 9;
        r = n % 9;
`ifndef TONE_SEQ_LOOP_EN
        if (n == 90) return '{addr: 4'd0, tone: 1'b0, busy: 1'b0, done: 1'b1};
        if (n > 90)  return '0;
`endif
        o.addr = 4'(k % 10);
        o.busy = 1'b1;
        o.done = 1'b0;
        if (r == 0)      o.tone = (k == 0) ? 1'b0 : exp_tone(8, note_tab[(k - 1) % 10]);
        else if (r == 1) o.tone = 1'b0;
        else             o.tone = exp_tone(r - 1, note_tab[k % 10]);
        return o;
    endfunction

    task automatic test_reset();
        obs_t got;
        rst = 1'b1; start = 1'b0; stop = 1'b0; corrupt = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        got = '{addr, tone, busy, done};
        total++;
        if (got !== '0 || dut.state_q !== IDLE) begin
            bad++;
            $display("FAIL reset_init got=%b state=%0d want=0000000 state=0", got, dut.state_q);
        end
        start = 1'b1; step(); start = 1'b0;
        repeat (12) step();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            got = '{addr, tone, busy, done};
            total++;
            if (got !== '0 || dut.state_q !== IDLE) begin
                bad++;
                $display("FAIL reset_mid%0d got=%b state=%0d want=0000000 state=0", i, got, dut.state_q);
            end
        end
        rst = 1'b0;
        step();
        got = '{addr, tone, busy, done};
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL reset_after got=%b want=0000000", got);
        end
    endtask

    // Tone timing, rests, db_entry changes during PLAY, a start during PLAY,
    // and either completion or three looped passes ended by stop.
    task automatic test_sequence();
        obs_t got, want;
        int   n_len;
`ifdef TONE_SEQ_LOOP_EN
        n_len = 3 * 90 + 5;
`else
        n_len = 95;
`endif
        for (int n = 0; n < n_len; n++) exp_q.push_back(exp_at(n));
        start = 1'b1; step(); start = 1'b0;
        for (int n = 0; n < n_len; n++) begin
            if (n > 0) step();
            got  = '{addr, tone, busy, done};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL seq n=%0d got addr=%0d tone=%b busy=%b done=%b want addr=%0d tone=%b busy=%b done=%b",
                         n, got.addr, got.tone, got.busy, got.done,
                         want.addr, want.tone, want.busy, want.done);
            end
            start   = (n == 20) || (n == 21);
            corrupt = want.busy && ((n % 9) >= 1) && ((n % 9) <= 7);
        end
        start = 1'b0; corrupt = 1'b0;
`ifdef TONE_SEQ_LOOP_EN
        stop = 1'b1; step(); stop = 1'b0;
        got = '{addr, tone, busy, done};
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL loop_stop got=%b want=0000000", got);
        end
`endif
    endtask

    task automatic test_abort();
        obs_t got, want;
        for (int n = 0; n <= 40; n++) exp_q.push_back(exp_at(n));
        start = 1'b1; step(); start = 1'b0;
        for (int n = 0; n <= 40; n++) begin
            if (n > 0) step();
            got  = '{addr, tone, busy, done};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL abort_pre n=%0d got=%b want=%b", n, got, want);
            end
        end
        stop = 1'b1; step(); stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            got = '{addr, tone, busy, done};
            total++;
            if (got !== '0 || dut.state_q !== IDLE) begin
                bad++;
                $display("FAIL abort_idle%0d got=%b state=%0d want=0000000 state=0", i, got, dut.state_q);
            end
            step();
        end
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (busy !== 1'b0 || dut.state_q !== IDLE) begin
                bad++;
                $display("FAIL start_stop%0d got busy=%b state=%0d want busy=0 state=0", i, busy, dut.state_q);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        obs_t got, want;
        for (int n = 0; n < 20; n++) exp_q.push_back(exp_at(n));
        start = 1'b1; step(); start = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (n > 0) step();
            got  = '{addr, tone, busy, done};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL restart n=%0d got=%b want=%b", n, got, want);
            end
        end
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    initial begin
        note_tab[0] = 8'd3; note_tab[1] = 8'd0; note_tab[2] = 8'd2; note_tab[3] = 8'd1;
        note_tab[4] = 8'd5; note_tab[5] = 8'd4; note_tab[6] = 8'd0; note_tab[7] = 8'd6;
        note_tab[8] = 8'd2; note_tab[9] = 8'd7;
        rst = 1'b1; start = 1'b0; stop = 1'b0; corrupt = 1'b0;
        test_reset();
        test_sequence();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
